// File: rtl/conversie_bcd_20b_pkg.sv
// Shared definitions for the binary-to-BCD converter slice.
package conversie_bcd_20b_pkg;

   // Default binary input width (also the number of shift iterations)
   localparam int unsigned WIDTH_DEF = 20;
   // Default number of BCD digits presented to the display driver
   localparam int unsigned NDIG_DEF  = 6;
   // Width of one BCD digit
   localparam int unsigned NIB_W     = 4;

   // Converter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : conversie_bcd_20b_pkg

// File: rtl/conversie_bcd_20b_if.sv
// Start/busy/done handshake plus operand and result bus of the converter.
interface conversie_bcd_20b_if
   import conversie_bcd_20b_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned NDIG  = NDIG_DEF
);

   logic                    start;
   logic [WIDTH-1:0]        bin;
   logic                    c_in;
   logic                    busy;
   logic                    done;
   logic [NIB_W*NDIG-1:0]   bcd;
   logic                    ovf;

   // Requester side (adder / sequencer)
   modport master (
      output start, bin, c_in,
      input  busy, done, bcd, ovf
   );

   // Converter side
   modport slave (
      input  start, bin, c_in,
      output busy, done, bcd, ovf
   );

endinterface : conversie_bcd_20b_if

// File: rtl/conversie_bcd_20b_corectie_bcd.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module corectie_bcd
   import conversie_bcd_20b_pkg::*;
(
   input  logic [NIB_W-1:0] din,
   output logic [NIB_W-1:0] dout_c
);

   // Add-3 when the digit would exceed 9 after doubling
   always_comb begin
      dout_c = din;
      if (din >= NIB_W'(5)) begin
         dout_c = din + NIB_W'(3);
      end
   end

endmodule : corectie_bcd

// File: rtl/conversie_bcd_20b.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock)
// placed after the 20-bit adder. One extra internal digit is kept only to
// detect values that do not fit in the displayed digits.
module conversie_bcd_20b
   import conversie_bcd_20b_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned NDIG  = NDIG_DEF
)
(
   input  logic                clk,
   input  logic                rst_n,
   conversie_bcd_20b_if.slave  bus
);

   localparam int unsigned BCD_W = NIB_W * (NDIG + 1);
   localparam int unsigned OUT_W = NIB_W * NDIG;
   localparam int unsigned SR_W  = BCD_W + WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [OUT_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;

   logic [BCD_W-1:0]   bcd_fix_c;
   logic [SR_W-1:0]    shift_c;

   // One correction cell per digit of the BCD field (including the guard digit)
   for (genvar g = 0; g < int'(NDIG) + 1; g++) begin : g_fix
      corectie_bcd u_fix (
         .din    (sr_q[WIDTH + NIB_W*g +: NIB_W]),
         .dout_c (bcd_fix_c[NIB_W*g +: NIB_W])
      );
   end

   // Corrected digits followed by the remaining binary bits, shifted left once
   always_comb begin
      shift_c = {bcd_fix_c, sr_q[WIDTH-1:0]} << 1;
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state, iteration control and result capture
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sr_d    = {{BCD_W{1'b0}}, bus.bin};
               carry_d = bus.c_in;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            sr_d  = shift_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            bcd_d   = sr_q[WIDTH +: OUT_W];
            ovf_d   = carry_q | (sr_q[SR_W-1 -: NIB_W] != '0);
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.bcd  = bcd_q;
   assign bus.ovf  = ovf_q;

endmodule : conversie_bcd_20b

// File: tb/tb_conversie_bcd_20b.sv
// Scoreboard bench for the binary-to-BCD converter.
module tb_conversie_bcd_20b;
   import conversie_bcd_20b_pkg::*;

   localparam int unsigned LAT = WIDTH_DEF + 1;

   typedef struct {
      logic [23:0] bcd;
      logic        ovf;
      int unsigned start_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   conversie_bcd_20b_if bus ();

   conversie_bcd_20b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          checks   = 0;
   int          errors   = 0;
   int unsigned cyc      = 0;
   int          busy_cnt = 0;
   int          done_cnt = 0;
   exp_t        sb[$];

   // Count rising edges so latency can be measured in clocks
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference decimal conversion
   function automatic logic [23:0] to_bcd(input int unsigned v);
      logic [23:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Drive a one-cycle start from the current falling edge
   task automatic kick(input int unsigned b, input logic c, input bit push);
      exp_t e;
      bus.start = 1'b1;
      bus.bin   = 20'(b);
      bus.c_in  = c;
      if (push) begin
         e.bcd       = to_bcd(b);
         e.ovf       = c | (b > 999999);
         e.start_cyc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 32'(n < 60), 32'd1);
   endtask

   task automatic conv(input int unsigned b, input logic c);
      @(negedge clk);
      kick(b, c, 1'b1);
      wait_done();
   endtask

   // Output monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("bcd", 32'(bus.bcd), 32'(e.bcd));
               chk("ovf", 32'(bus.ovf), 32'(e.ovf));
               chk("latency", cyc - e.start_cyc, LAT);
               chk("busy_cycles", 32'(busy_cnt), LAT);
               chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
            busy_cnt = 0;
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.bin   = '0;
      bus.c_in  = 1'b0;
      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_bcd",  32'(bus.bcd),  32'd0);
      chk("rst_ovf",  32'(bus.ovf),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      conv(0, 1'b0);
      conv(123456, 1'b0);
      conv(999999, 1'b0);
      conv(1000000, 1'b0);
      conv(1048575, 1'b0);
      conv(42, 1'b1);

      // Operands change while busy; a second start mid-conversion is ignored
      @(negedge clk);
      kick(777, 1'b0, 1'b1);
      bus.bin  = 20'd555;
      bus.c_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      // Start in the cycle right after done
      kick(555, 1'b0, 1'b1);
      wait_done();

      // Asynchronous abort partway through a conversion
      @(negedge clk);
      kick(654321, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_bcd",  32'(bus.bcd),  32'd0);
      chk("abort_ovf",  32'(bus.ovf),  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      conv(31, 1'b0);

      repeat (3) @(negedge clk);
      chk("done_count", 32'(done_cnt), 32'd9);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_conversie_bcd_20b
